// File: rtl/surf_id_pkg.sv
// surf_id_pkg: shared definitions for the SURF ID/control register reader.
// Register byte offsets within the ID/control target, the DNA latch command,
// the default DNA length and the state encodings of the reader and of its
// single-access bus engine.
package surf_id_pkg;

  localparam logic [10:0] ID_OFS       = 11'h000;
  localparam logic [10:0] VERSION_OFS  = 11'h004;
  localparam logic [10:0] DNA_OFS      = 11'h008;
  localparam logic [10:0] CTRLSTAT_OFS = 11'h00C;

  // Writing this word to the DNA register copies the device DNA into the
  // target's shift register; only the top byte lane carries the command bit.
  localparam logic [31:0] DNA_LATCH_WORD = 32'h8000_0000;
  localparam logic [3:0]  DNA_LATCH_SEL  = 4'b1000;

  localparam int DNA_BITS_DEFAULT = 96;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DEV,
    ST_RD_VER,
    ST_DNA_LATCH,
    ST_DNA_SHIFT,
    ST_DONE,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WAIT,
    ACC_GAP
  } acc_state_e;

endpackage

// File: rtl/wb_single_access.sv
// wb_single_access: runs one Wishbone classic access at a time for the
// surf_id_reader sequencer. Bus signals are registered and held until the
// terminating cycle, then dropped for at least one idle cycle. A retry is
// reissued internally after that idle cycle; the caller only sees done/err.
// Optional ack watchdog: define SURF_ID_READER_TIMEOUT_EN.
module wb_single_access
  import surf_id_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [10:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        idle_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [10:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  acc_state_e  state_q, state_d;
  logic        active_q, active_d;
  logic        we_q, we_d;
  logic [10:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;

  logic waiting;
  logic any_term;
  logic retry;
  logic timeout;

  assign waiting  = (state_q == ACC_WAIT);
  assign any_term = wb_ack_i | wb_err_i | wb_rty_i;

`ifdef SURF_ID_READER_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wdog_q, wdog_d;

  // Count stalled cycles while the strobe waits for any termination.
  always_comb begin
    wdog_d = 8'd0;
    if (waiting && !any_term) begin
      wdog_d = wdog_q + 8'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 8'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign timeout = waiting && !any_term && (wdog_q == WDOG_LAST);
`else
  // Without the watchdog the limit has no effect and the access waits forever.
  assign timeout = 1'b0 && (TIMEOUT > 0);
`endif

  // Error beats ack; a stalled access that hits the limit counts as an error.
  assign err_o   = waiting & (wb_err_i | timeout);
  assign done_o  = waiting & wb_ack_i & ~wb_err_i;
  assign retry   = waiting & wb_rty_i & ~wb_ack_i & ~wb_err_i;
  assign idle_o  = (state_q == ACC_IDLE);
  assign rdata_o = wb_dat_i;

  assign wb_cyc_o = active_q;
  assign wb_stb_o = active_q;
  assign wb_we_o  = active_q & we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

  // Accept a request when idle, release on termination, reissue after a retry gap.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    case (state_q)
      ACC_IDLE: begin
        if (req_i) begin
          state_d  = ACC_WAIT;
          active_d = 1'b1;
          we_d     = we_i;
          adr_d    = adr_i;
          dat_d    = dat_i;
          sel_d    = sel_i;
        end
      end
      ACC_WAIT: begin
        if (done_o || err_o) begin
          state_d  = ACC_IDLE;
          active_d = 1'b0;
        end else if (retry) begin
          state_d  = ACC_GAP;
          active_d = 1'b0;
        end
      end
      ACC_GAP: begin
        state_d  = ACC_WAIT;
        active_d = 1'b1;
      end
      default: begin
        state_d  = ACC_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // Bus-facing registers; reset drops the strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACC_IDLE;
      active_q <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 11'h000;
      dat_q    <= 32'h0;
      sel_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: rtl/surf_id_reader.sv
// surf_id_reader: Wishbone initiator that reads DEVICE and VERSION from the
// SURF ID/control block, latches the device DNA and shifts it out one bit per
// read, presenting the results as registered outputs.
// Optional ack watchdog in the access engine: define SURF_ID_READER_TIMEOUT_EN.
module surf_id_reader
  import surf_id_pkg::*;
#(
  parameter logic [10:0] BASE_ADR   = 11'h000,
  parameter int          DNA_BITS   = DNA_BITS_DEFAULT,
  parameter bit          AUTO_START = 1'b1,
  parameter int          TIMEOUT    = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                start_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [10:0]         wb_adr_o,
  output logic [31:0]         wb_dat_o,
  output logic [3:0]          wb_sel_o,
  input  logic [31:0]         wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_rty_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [31:0]         device_o,
  output logic [31:0]         version_o,
  output logic [DNA_BITS-1:0] dna_o,
  output logic                dna_valid_o
);

  localparam logic [6:0] LAST_BIT = 7'(DNA_BITS - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                dna_valid_q, dna_valid_d;
  logic                auto_q, auto_d;
  logic [31:0]         device_q, device_d;
  logic [31:0]         version_q, version_d;
  logic [DNA_BITS-1:0] dna_sr_q, dna_sr_d;
  logic [DNA_BITS-1:0] dna_q, dna_d;
  logic [6:0]          bit_cnt_q, bit_cnt_d;

  logic        acc_req;
  logic        acc_we;
  logic [10:0] acc_adr;
  logic [31:0] acc_dat;
  logic [3:0]  acc_sel;
  logic        acc_idle;
  logic        acc_done;
  logic        acc_err;
  logic [31:0] acc_rdata;
  logic        go;

  assign go = start_i | auto_q;

  wb_single_access #(
    .TIMEOUT (TIMEOUT)
  ) u_access (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .req_i    (acc_req),
    .we_i     (acc_we),
    .adr_i    (acc_adr),
    .dat_i    (acc_dat),
    .sel_i    (acc_sel),
    .idle_o   (acc_idle),
    .done_o   (acc_done),
    .err_o    (acc_err),
    .rdata_o  (acc_rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i)
  );

  // Sequence the accesses; the first one is issued from IDLE so the strobe rises on the start edge.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    dna_valid_d = dna_valid_q;
    auto_d      = auto_q;
    device_d    = device_q;
    version_d   = version_q;
    dna_sr_d    = dna_sr_q;
    dna_d       = dna_q;
    bit_cnt_d   = bit_cnt_q;
    acc_req     = 1'b0;
    acc_we      = 1'b0;
    acc_adr     = BASE_ADR + ID_OFS;
    acc_dat     = 32'h0;
    acc_sel     = 4'hF;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d     = ST_RD_DEV;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          dna_valid_d = 1'b0;
          auto_d      = 1'b0;
          bit_cnt_d   = 7'd0;
          acc_req     = 1'b1;
        end
      end
      ST_RD_DEV: begin
        acc_req = acc_idle;
        if (acc_err) begin
          state_d = ST_FAULT;
        end else if (acc_done) begin
          device_d = acc_rdata;
          state_d  = ST_RD_VER;
        end
      end
      ST_RD_VER: begin
        acc_adr = BASE_ADR + VERSION_OFS;
        acc_req = acc_idle;
        if (acc_err) begin
          state_d = ST_FAULT;
        end else if (acc_done) begin
          version_d = acc_rdata;
          state_d   = ST_DNA_LATCH;
        end
      end
      ST_DNA_LATCH: begin
        acc_adr = BASE_ADR + DNA_OFS;
        acc_we  = 1'b1;
        acc_dat = DNA_LATCH_WORD;
        acc_sel = DNA_LATCH_SEL;
        acc_req = acc_idle;
        if (acc_err) begin
          state_d = ST_FAULT;
        end else if (acc_done) begin
          bit_cnt_d = 7'd0;
          state_d   = ST_DNA_SHIFT;
        end
      end
      ST_DNA_SHIFT: begin
        acc_adr = BASE_ADR + DNA_OFS;
        acc_req = acc_idle;
        if (acc_err) begin
          state_d = ST_FAULT;
        end else if (acc_done) begin
          dna_sr_d = {acc_rdata[0], dna_sr_q[DNA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
      ST_DONE: begin
        done_d      = 1'b1;
        dna_valid_d = 1'b1;
        busy_d      = 1'b0;
        dna_d       = dna_sr_q;
        state_d     = ST_IDLE;
      end
      ST_FAULT: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and captured identity registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dna_valid_q <= 1'b0;
      auto_q      <= AUTO_START;
      device_q    <= 32'h0;
      version_q   <= 32'h0;
      dna_sr_q    <= '0;
      dna_q       <= '0;
      bit_cnt_q   <= 7'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dna_valid_q <= dna_valid_d;
      auto_q      <= auto_d;
      device_q    <= device_d;
      version_q   <= version_d;
      dna_sr_q    <= dna_sr_d;
      dna_q       <= dna_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dna_valid_o = dna_valid_q;
  assign device_o    = device_q;
  assign version_o   = version_q;
  assign dna_o       = dna_q;

endmodule

// File: tb/tb_surf_id_reader.sv
// tb_surf_id_reader: directed bench for surf_id_reader against a small
// ID/control target model with a registered one-cycle ack.
// Honours SURF_ID_READER_TIMEOUT_EN for the stalled-latch scenario.
module tb_surf_id_reader;

  localparam int          LIMIT       = 2000;
  localparam logic [31:0] DEVICE_VAL  = 32'h5355_5246;
  localparam logic [31:0] VERSION_VAL = 32'h0102_0003;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic        start_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [10:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] device_o;
  logic [31:0] version_o;
  logic [95:0] dna_o;
  logic        dna_valid_o;

  logic [95:0] dna_val = 96'h0123_4567_89AB_CDEF_0011_2233;

  bit          err_ver      = 1'b0;
  bit          rty_dev      = 1'b0;
  bit          no_ack_latch = 1'b0;
  bit          rty_given    = 1'b0;
  bit          last_was_rty = 1'b0;
  bit          latch_ok     = 1'b0;
  logic [10:0] reissue_adr  = 11'h7FF;
  int          acc_count    = 0;
  int          dna_ptr      = 0;

  int assert_count = 0;
  int fail_count   = 0;

  surf_id_reader dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .start_i     (start_i),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .wb_rty_i    (wb_rty_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .device_o    (device_o),
    .version_o   (version_o),
    .dna_o       (dna_o),
    .dna_valid_o (dna_valid_o)
  );

  // Free-running bus clock.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Target model: answers one cycle after it sees a fresh strobe, with fault knobs.
  always @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_i  <= 1'b0;
      wb_err_i  <= 1'b0;
      wb_rty_i  <= 1'b0;
      wb_dat_i  <= 32'h0;
      rty_given <= 1'b0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_rty_i <= 1'b0;
      if (!rty_dev) rty_given <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !wb_rty_i) begin
        if (!wb_we_o && wb_adr_o == 11'h000) begin
          acc_count <= acc_count + 1;
          if (last_was_rty) reissue_adr <= wb_adr_o;
          last_was_rty <= 1'b0;
          if (rty_dev && !rty_given) begin
            wb_rty_i     <= 1'b1;
            rty_given    <= 1'b1;
            last_was_rty <= 1'b1;
          end else begin
            wb_ack_i <= 1'b1;
            wb_dat_i <= DEVICE_VAL;
          end
        end else if (!wb_we_o && wb_adr_o == 11'h004) begin
          acc_count <= acc_count + 1;
          if (err_ver) begin
            wb_err_i <= 1'b1;
          end else begin
            wb_ack_i <= 1'b1;
            wb_dat_i <= VERSION_VAL;
          end
        end else if (wb_we_o && wb_adr_o == 11'h008) begin
          if (!no_ack_latch) begin
            acc_count <= acc_count + 1;
            wb_ack_i  <= 1'b1;
            latch_ok  <= (wb_dat_o == 32'h8000_0000) && (wb_sel_o == 4'b1000);
            dna_ptr   <= 0;
          end
        end else if (!wb_we_o && wb_adr_o == 11'h008) begin
          acc_count <= acc_count + 1;
          wb_ack_i  <= 1'b1;
          wb_dat_i  <= (dna_ptr < 96) ? {31'b0, dna_val[dna_ptr]} : 32'h0;
          dna_ptr   <= dna_ptr + 1;
        end else begin
          acc_count <= acc_count + 1;
          wb_err_i  <= 1'b1;
        end
      end
    end
  end

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Step negedges until done_o or err_o, optionally re-pulsing start_i mid-run.
  task automatic waitDone(input int extra_at, output int cycles);
    bit err_prev;
    err_prev = 1'b0;
    cycles   = 0;
    while (!(done_o || err_o) && cycles < LIMIT) begin
      if (cycles == extra_at) start_i = 1'b1;
      @(negedge wb_clk_i);
      start_i = 1'b0;
      cycles++;
      if (err_prev) checkOutput("cyc_after_err", wb_cyc_o, 1'b0);
      err_prev = wb_err_i;
    end
    checkOutput("run_in_bound", cycles < LIMIT, 1'b1);
    checkOutput("busy_fall", busy_o, 1'b0);
  endtask

  // Pulse start_i for one cycle and wait for the sequence to end.
  task automatic applyStimulus(input int extra_at, output int cycles);
    @(negedge wb_clk_i);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    checkOutput("busy_rise", busy_o, 1'b1);
    waitDone(extra_at, cycles);
  endtask

  // Check the identity captured by a clean run.
  task automatic checkResult(input string tag);
    checkOutput({tag, "_device"}, device_o, DEVICE_VAL);
    checkOutput({tag, "_version"}, version_o, VERSION_VAL);
    checkOutput({tag, "_dna"}, dna_o, dna_val);
    checkOutput({tag, "_done"}, done_o, 1'b1);
    checkOutput({tag, "_dna_valid"}, dna_valid_o, 1'b1);
    checkOutput({tag, "_err"}, err_o, 1'b0);
    checkOutput({tag, "_latch_word"}, latch_ok, 1'b1);
  endtask

  // Hard stop in case something upstream of the bounded waits hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] aborted");
  end

  // Directed scenarios in order.
  initial begin
    int cycles;
    int base;
    int n;

    wb_rst_ni = 1'b0;
    start_i   = 1'b0;
    repeat (3) @(negedge wb_clk_i);

    $display("[TB] reset values");
    checkOutput("rst_cyc", wb_cyc_o, 1'b0);
    checkOutput("rst_stb", wb_stb_o, 1'b0);
    checkOutput("rst_we", wb_we_o, 1'b0);
    checkOutput("rst_adr", wb_adr_o, 11'h000);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_done", done_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_dna_valid", dna_valid_o, 1'b0);
    checkOutput("rst_device", device_o, 32'h0);
    checkOutput("rst_dna", dna_o, 96'h0);

    $display("[TB] automatic run after reset release");
    base = acc_count;
    wb_rst_ni = 1'b1;
    waitDone(-1, cycles);
    checkOutput("auto_cycles", cycles, 298);
    checkResult("auto");
    checkOutput("auto_accesses", acc_count - base, 99);

    $display("[TB] started run with a second start at cycle 50");
    repeat (3) @(negedge wb_clk_i);
    base = acc_count;
    applyStimulus(50, cycles);
    checkOutput("run_cycles", cycles, 297);
    repeat (10) @(negedge wb_clk_i);
    checkResult("run");
    checkOutput("run_accesses", acc_count - base, 99);
    checkOutput("run_idle_after", busy_o, 1'b0);

    $display("[TB] retry on the DEVICE read");
    rty_dev = 1'b1;
    base = acc_count;
    applyStimulus(-1, cycles);
    checkOutput("rty_cycles", cycles, 300);
    checkOutput("rty_reissue_adr", reissue_adr, 11'h000);
    checkOutput("rty_accesses", acc_count - base, 100);
    checkResult("rty");
    rty_dev = 1'b0;

    $display("[TB] error on the VERSION read");
    err_ver = 1'b1;
    base = acc_count;
    applyStimulus(-1, cycles);
    checkOutput("err_cycles", cycles, 6);
    checkOutput("err_err", err_o, 1'b1);
    checkOutput("err_done", done_o, 1'b0);
    checkOutput("err_dna_valid", dna_valid_o, 1'b0);
    repeat (20) @(negedge wb_clk_i);
    checkOutput("err_accesses", acc_count - base, 2);
    checkOutput("err_bus_idle", wb_cyc_o, 1'b0);
    checkOutput("err_sticky", err_o, 1'b1);
    err_ver = 1'b0;

    $display("[TB] DNA latch write never acknowledged");
    no_ack_latch = 1'b1;
`ifdef SURF_ID_READER_TIMEOUT_EN
    applyStimulus(-1, cycles);
    checkOutput("tmo_cycles", cycles, 262);
    checkOutput("tmo_err", err_o, 1'b1);
    checkOutput("tmo_stb", wb_stb_o, 1'b0);
    checkOutput("tmo_dna_valid", dna_valid_o, 1'b0);
    no_ack_latch = 1'b0;
`else
    @(negedge wb_clk_i);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    repeat (300) @(negedge wb_clk_i);
    checkOutput("stall_busy", busy_o, 1'b1);
    checkOutput("stall_stb", wb_stb_o, 1'b1);
    checkOutput("stall_we", wb_we_o, 1'b1);
    checkOutput("stall_adr", wb_adr_o, 11'h008);
    checkOutput("stall_dat", wb_dat_o, 32'h8000_0000);
    checkOutput("stall_sel", wb_sel_o, 4'b1000);
    checkOutput("stall_err", err_o, 1'b0);
    wb_rst_ni = 1'b0;
    no_ack_latch = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    waitDone(-1, cycles);
    checkResult("stall_recover");
`endif

    $display("[TB] reset during the DNA shift");
    repeat (3) @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    n = 0;
    while (!(dna_ptr == 40 && wb_stb_o) && n < LIMIT) begin
      @(negedge wb_clk_i);
      n++;
    end
    checkOutput("mid_reach_bit40", n < LIMIT, 1'b1);
    #1;
    wb_rst_ni = 1'b0;
    #1;
    checkOutput("mid_cyc", wb_cyc_o, 1'b0);
    checkOutput("mid_stb", wb_stb_o, 1'b0);
    checkOutput("mid_busy", busy_o, 1'b0);
    checkOutput("mid_device", device_o, 32'h0);
    checkOutput("mid_version", version_o, 32'h0);
    checkOutput("mid_dna", dna_o, 96'h0);
    checkOutput("mid_done", done_o, 1'b0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    waitDone(-1, cycles);
    checkOutput("mid_auto_cycles", cycles, 298);
    checkResult("mid_auto");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
